// File: rtl/ctr_req_arbiter_if.sv
// Counter request offer bus: one registered offer (address + direction)
// held by the arbiter until the counter sequencer acknowledges it.
interface ctr_req_arbiter_if #(
    parameter int ADDRW = 6
);
    logic             req_valid;
    logic [ADDRW-1:0] req_addr;
    logic             req_dir;
    logic             req_ack;

    modport master (output req_valid, req_addr, req_dir, input req_ack);
    modport slave  (input req_valid, req_addr, req_dir, output req_ack);
endinterface

// File: rtl/ctr_req_arbiter.sv
// ctr_req_arbiter: latches plus/minus involuntary-counter pulses per channel
// and arbitrates them (fixed priority or round-robin) into a single offer.
// Optional feature macro: CTRREQ_PM_CANCEL_EN (P and M pending on the same,
// not-offered channel cancel each other out).
module ctr_req_arbiter #(
    parameter int NCH       = 16,
    parameter int ADDRW     = 6,
    parameter int BASE_ADDR = 26,
    parameter int RR        = 0
) (
    input  logic                CLOCK,
    input  logic                rst,
    input  logic [NCH-1:0]      pulse_p,
    input  logic [NCH-1:0]      pulse_m,
    input  logic                clr_ovf,
    output logic [NCH-1:0]      ovf,
    ctr_req_arbiter_if.master   req
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    generate
        if (NCH < 1 || NCH > 32) begin : g_bad_nch
            $error("ctr_req_arbiter: NCH must be in 1..32");
        end
        if (BASE_ADDR + NCH - 1 >= (1 << ADDRW)) begin : g_bad_addr
            $error("ctr_req_arbiter: BASE_ADDR+NCH-1 does not fit in ADDRW bits");
        end
    endgenerate

    logic [NCH-1:0]   samp_p, prev_p, samp_m, prev_m;
    logic [NCH-1:0]   rise_p, rise_m;
    logic [NCH-1:0]   lat_p, lat_m;
    logic [NCH-1:0]   clr_p, clr_m;
    logic [NCH-1:0]   cancel;
    logic [NCH-1:0]   elig_p, elig_m, elig;
    logic [0:0]       state;
    logic [IW-1:0]    gidx;
    logic             gdir;
    logic [IW-1:0]    ptr;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic             win_dir;
    logic             off_valid;
    logic [ADDRW-1:0] off_addr;
    logic             off_dir;

    assign req.req_valid = off_valid;
    assign req.req_addr  = off_addr;
    assign req.req_dir   = off_dir;

    assign rise_p = samp_p & ~prev_p;
    assign rise_m = samp_m & ~prev_m;

    // Edge-detect registers; during reset they track the inputs so a level
    // already high at release is treated as seen and raises no request.
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            samp_p <= pulse_p;
            prev_p <= pulse_p;
            samp_m <= pulse_m;
            prev_m <= pulse_m;
        end else begin
            samp_p <= pulse_p;
            prev_p <= samp_p;
            samp_m <= pulse_m;
            prev_m <= samp_m;
        end
    end

    // Latch-clear strobes for the granted channel/direction on acknowledge.
    always_comb begin
        clr_p = '0;
        clr_m = '0;
        if (state == ST_OFFER && req.req_ack) begin
            if (gdir) clr_m[gidx] = 1'b1;
            else      clr_p[gidx] = 1'b1;
        end
    end

`ifdef CTRREQ_PM_CANCEL_EN
    logic [NCH-1:0] offered;

    // Mask of the channel currently on the bus; it is exempt from cancel.
    always_comb begin
        offered = '0;
        if (state == ST_OFFER) offered[gidx] = 1'b1;
    end

    assign cancel = lat_p & lat_m & ~offered;
`else
    assign cancel = '0;
`endif

    assign elig_p = lat_p & ~cancel;
    assign elig_m = lat_m & ~cancel;
    assign elig   = elig_p | elig_m;

    // Winner search: rotating start after the last grant for RR, else index 0.
    always_comb begin
        int start;
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        start     = 0;
        idx       = 0;
        if (RR != 0) begin
            start = int'(ptr) + 1;
            if (start >= NCH) start = 0;
        end
        for (int k = 0; k < NCH; k++) begin
            idx = start + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    // Plus wins over minus within the same channel.
    assign win_dir = ~elig_p[win_idx];

    // Request latches and sticky overrun flags; a new edge beats a clear.
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            lat_p <= '0;
            lat_m <= '0;
            ovf   <= '0;
        end else begin
            lat_p <= (lat_p & ~clr_p & ~cancel) | rise_p;
            lat_m <= (lat_m & ~clr_m & ~cancel) | rise_m;
            ovf   <= (ovf & ~{NCH{clr_ovf}})
                   | (rise_p & lat_p & ~clr_p)
                   | (rise_m & lat_m & ~clr_m);
        end
    end

    // Offer FSM: load a winner from IDLE, hold it frozen until acknowledged.
    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state     <= ST_IDLE;
            off_valid <= 1'b0;
            off_addr  <= '0;
            off_dir   <= 1'b0;
            gidx      <= '0;
            gdir      <= 1'b0;
            ptr       <= IW'(NCH - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state     <= ST_OFFER;
                        off_valid <= 1'b1;
                        off_addr  <= ADDRW'(BASE_ADDR + int'(win_idx));
                        off_dir   <= win_dir;
                        gidx      <= win_idx;
                        gdir      <= win_dir;
                        ptr       <= win_idx;
                    end
                end
                default: begin
                    if (req.req_ack) begin
                        state     <= ST_IDLE;
                        off_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
